// File: rtl/vec_axis_pkg.sv
// rtl/vec_axis_pkg.sv - shared types and sizing helpers for the vector-to-AXIS serialiser
package vec_axis_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int beats(input int vec_bytes, input int axis_bytes);
        return vec_bytes / axis_bytes;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int cwidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vec_beat_mux.sv
// rtl/vec_beat_mux.sv - selects one AXIS beat from the snapshot by channel and beat index
module vec_beat_mux
    import vec_axis_pkg::*;
#(
    parameter int VEC_BYTES  = 2,
    parameter int AXIS_BYTES = 1,
    parameter int N_CH       = 4,
    parameter bit MSB_FIRST  = 1'b0,
    localparam int BEATS     = beats(VEC_BYTES, AXIS_BYTES),
    localparam int CW        = cwidth(N_CH),
    localparam int BW        = cwidth(BEATS)
) (
    input  logic [N_CH*VEC_BYTES*8-1:0] snap,
    input  logic [CW-1:0]               ch,
    input  logic [BW-1:0]               beat,
    output logic [AXIS_BYTES*8-1:0]     tdata
);

    localparam int VW = VEC_BYTES * 8;
    localparam int AW = AXIS_BYTES * 8;

    logic [VW-1:0] word;

    // Loop-and-compare keeps every part-select constant and in range.
    always_comb begin
        word  = '0;
        tdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(ch) == i) begin
                word = snap[i*VW +: VW];
            end
        end
        for (int k = 0; k < BEATS; k++) begin
            if (int'(beat) == k) begin
                tdata = word[(MSB_FIRST ? (BEATS - 1 - k) : k)*AW +: AW];
            end
        end
    end

endmodule

// File: rtl/vectors_to_axis_tdest_seq.sv
// rtl/vectors_to_axis_tdest_seq.sv - serialises snapshotted channel vectors into TDEST-tagged AXIS packets
module vectors_to_axis_tdest_seq
    import vec_axis_pkg::*;
#(
    parameter int VEC_BYTES   = 2,
    parameter int AXIS_BYTES  = 1,
    parameter int N_CH        = 4,
    parameter bit MSB_FIRST   = 1'b0,
    parameter int TDEST_WIDTH = 4,
    parameter int TDEST_BASE  = 0,
    parameter bit CONTINUOUS  = 1'b1
) (
    input  logic                        clk,
    input  logic                        sresetn,
    input  logic [N_CH*VEC_BYTES*8-1:0] vec,
    input  logic [N_CH-1:0]             ch_enable,
    input  logic                        trigger,
    output logic                        busy,
    output logic [AXIS_BYTES*8-1:0]     axis_tdata,
    output logic [AXIS_BYTES-1:0]       axis_tkeep,
    output logic                        axis_tvalid,
    input  logic                        axis_tready,
    output logic                        axis_tlast,
    output logic [TDEST_WIDTH-1:0]      axis_tdest
);

    localparam int BEATS = beats(VEC_BYTES, AXIS_BYTES);
    localparam int CW    = cwidth(N_CH);
    localparam int BW    = cwidth(BEATS);
    localparam int SW    = N_CH * VEC_BYTES * 8;

    generate
        if (N_CH < 1) begin : g_bad_nch
            $error("N_CH must be at least 1");
        end
        if ((VEC_BYTES % AXIS_BYTES) != 0) begin : g_bad_bytes
            $error("VEC_BYTES must be a multiple of AXIS_BYTES");
        end
        if ((TDEST_BASE + N_CH - 1) >= (2 ** TDEST_WIDTH)) begin : g_bad_tdest
            $error("TDEST_BASE+N_CH-1 does not fit in TDEST_WIDTH");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [SW-1:0]   snap_q, snap_d;
    logic [N_CH-1:0] en_q, en_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            pending_q, pending_d;

    logic            last_beat;
    logic            accept;
    logic            frame_end;
    logic            trig_ok;
    logic            snap_ev;
    logic            has_next;
    logic [CW-1:0]   next_ch;
    logic            has_first;
    logic [CW-1:0]   first_ch;

    // Priority searches: lowest enabled channel above ch_q, and lowest in the live enables.
    always_comb begin
        has_next  = 1'b0;
        next_ch   = ch_q;
        has_first = 1'b0;
        first_ch  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en_q[i] && (i > int'(ch_q))) begin
                has_next = 1'b1;
                next_ch  = CW'(i);
            end
            if (ch_enable[i]) begin
                has_first = 1'b1;
                first_ch  = CW'(i);
            end
        end
    end

    always_comb begin
        last_beat = (beat_q == BW'(BEATS - 1));
        accept    = (state_q == SEND) && axis_tready;
        frame_end = accept && last_beat && !has_next;
        trig_ok   = !CONTINUOUS && trigger;

        case (state_q)
            IDLE:    snap_ev = CONTINUOUS || trig_ok || pending_q;
            SEND:    snap_ev = frame_end && (CONTINUOUS || pending_q || trig_ok);
            default: snap_ev = 1'b0;
        endcase

        state_d   = state_q;
        snap_d    = snap_q;
        en_d      = en_q;
        ch_d      = ch_q;
        beat_d    = beat_q;
        pending_d = pending_q;

        if (snap_ev) begin
            snap_d    = vec;
            en_d      = ch_enable;
            ch_d      = first_ch;
            beat_d    = '0;
            pending_d = 1'b0;
            state_d   = has_first ? SEND : IDLE;
        end else if (accept) begin
            if (last_beat) begin
                if (has_next) begin
                    ch_d   = next_ch;
                    beat_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end

        // A trigger that cannot start a frame right now is remembered once.
        if (!snap_ev && (state_q == SEND) && trig_ok) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            en_q      <= '0;
            ch_q      <= '0;
            beat_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            en_q      <= en_d;
            ch_q      <= ch_d;
            beat_q    <= beat_d;
            pending_q <= pending_d;
        end
    end

    vec_beat_mux #(
        .VEC_BYTES  (VEC_BYTES),
        .AXIS_BYTES (AXIS_BYTES),
        .N_CH       (N_CH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_mux (
        .snap  (snap_q),
        .ch    (ch_q),
        .beat  (beat_q),
        .tdata (axis_tdata)
    );

    assign axis_tvalid = (state_q == SEND);
    assign axis_tlast  = (state_q == SEND) && last_beat;
    assign axis_tkeep  = '1;
    assign axis_tdest  = TDEST_WIDTH'(TDEST_BASE) + TDEST_WIDTH'(ch_q);
    assign busy        = (state_q == SEND) || pending_q;

endmodule

// File: tb/tb_vectors_to_axis_tdest_seq.sv
// tb/tb_vectors_to_axis_tdest_seq.sv - randomized queue-model bench for a continuous and a triggered instance
module tb_vectors_to_axis_tdest_seq;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [3:0] t;
    } beat_t;
    typedef beat_t bq_t[$];

    logic        clk = 1'b0;
    logic        sresetn;
    logic [31:0] veca;
    logic [1:0]  ena;
    logic        triga, trdya;
    logic [63:0] vecb;
    logic [3:0]  enb;
    logic        trigb, trdyb;

    logic        a_busy, a_tvalid, a_tlast, a_tkeep;
    logic [7:0]  a_tdata;
    logic [3:0]  a_tdest;
    logic        b_busy, b_tvalid, b_tlast, b_tkeep;
    logic [7:0]  b_tdata;
    logic [3:0]  b_tdest;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_on = 1'b0;

    bq_t qa, qb, capa, capb;
    bit  pendb = 1'b0;

    always #5 clk = ~clk;

    vectors_to_axis_tdest_seq #(
        .VEC_BYTES(2), .AXIS_BYTES(1), .N_CH(2), .MSB_FIRST(1'b0),
        .TDEST_WIDTH(4), .TDEST_BASE(0), .CONTINUOUS(1'b1)
    ) dut_a (
        .clk(clk), .sresetn(sresetn), .vec(veca), .ch_enable(ena), .trigger(triga),
        .busy(a_busy), .axis_tdata(a_tdata), .axis_tkeep(a_tkeep), .axis_tvalid(a_tvalid),
        .axis_tready(trdya), .axis_tlast(a_tlast), .axis_tdest(a_tdest)
    );

    vectors_to_axis_tdest_seq #(
        .VEC_BYTES(2), .AXIS_BYTES(1), .N_CH(4), .MSB_FIRST(1'b1),
        .TDEST_WIDTH(4), .TDEST_BASE(8), .CONTINUOUS(1'b0)
    ) dut_b (
        .clk(clk), .sresetn(sresetn), .vec(vecb), .ch_enable(enb), .trigger(trigb),
        .busy(b_busy), .axis_tdata(b_tdata), .axis_tkeep(b_tkeep), .axis_tvalid(b_tvalid),
        .axis_tready(trdyb), .axis_tlast(b_tlast), .axis_tdest(b_tdest)
    );

    // Whole frame as an ordered list of beats, straight from the packet rules.
    function automatic bq_t frame(input logic [63:0] v, input logic [3:0] en, input int n,
                                  input bit msb, input int base);
        bq_t   r;
        beat_t b;
        int    idx;
        for (int ch = 0; ch < n; ch++) begin
            if (en[ch]) begin
                for (int k = 0; k < 2; k++) begin
                    idx = msb ? (1 - k) : k;
                    b.d = v[(ch*2 + idx)*8 +: 8];
                    b.l = (k == 1);
                    b.t = 4'(base + ch);
                    r.push_back(b);
                end
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!sresetn) begin
            qa.delete();
            qb.delete();
            pendb = 1'b0;
        end else begin
            if (qa.size() > 0 && trdya) void'(qa.pop_front());
            if (qa.size() == 0) qa = frame({32'h0, veca}, {2'b00, ena}, 2, 1'b0, 0);
            if (qb.size() > 0 && trdyb) void'(qb.pop_front());
            if (qb.size() == 0) begin
                if (trigb || pendb) begin
                    qb    = frame(vecb, enb, 4, 1'b1, 8);
                    pendb = 1'b0;
                end
            end else if (trigb) begin
                pendb = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (sresetn && a_tvalid && trdya) capa.push_back('{a_tdata, a_tlast, a_tdest});
        if (sresetn && b_tvalid && trdyb) capb.push_back('{b_tdata, b_tlast, b_tdest});
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_tvalid", 32'(a_tvalid), 32'(qa.size() > 0));
            chk("a_busy",   32'(a_busy),   32'(qa.size() > 0));
            chk("a_tkeep",  32'(a_tkeep),  32'd1);
            if (qa.size() > 0) begin
                chk("a_tdata", 32'(a_tdata), 32'(qa[0].d));
                chk("a_tlast", 32'(a_tlast), 32'(qa[0].l));
                chk("a_tdest", 32'(a_tdest), 32'(qa[0].t));
            end
            chk("b_tvalid", 32'(b_tvalid), 32'(qb.size() > 0));
            chk("b_busy",   32'(b_busy),   32'((qb.size() > 0) || pendb));
            chk("b_tkeep",  32'(b_tkeep),  32'd1);
            if (qb.size() > 0) begin
                chk("b_tdata", 32'(b_tdata), 32'(qb[0].d));
                chk("b_tlast", 32'(b_tlast), 32'(qb[0].l));
                chk("b_tdest", 32'(b_tdest), 32'(qb[0].t));
            end
        end
    end

    task automatic pulse_trigb();
        @(posedge clk); #2 trigb = 1'b1;
        @(posedge clk); #2 trigb = 1'b0;
    endtask

    task automatic wait_b_idle(input string nm);
        bit idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            idle = !b_busy;
        end
        chk(nm, 32'(idle), 32'd1);
    endtask

    beat_t exp_a[4];
    beat_t exp_b[4];
    bit    found;

    initial begin
        exp_a[0] = '{8'hEF, 1'b0, 4'd0};
        exp_a[1] = '{8'hBE, 1'b1, 4'd0};
        exp_a[2] = '{8'h34, 1'b0, 4'd1};
        exp_a[3] = '{8'h12, 1'b1, 4'd1};
        exp_b[0] = '{8'h12, 1'b0, 4'd9};
        exp_b[1] = '{8'h34, 1'b1, 4'd9};
        exp_b[2] = '{8'hCA, 1'b0, 4'd11};
        exp_b[3] = '{8'hFE, 1'b1, 4'd11};

        sresetn = 1'b0;
        veca  = {16'h1234, 16'hBEEF};
        ena   = 2'b11;
        triga = 1'b0;
        trdya = 1'b1;
        vecb  = 64'hCAFE_BEEF_1234_5678;
        enb   = 4'b1010;
        trigb = 1'b0;
        trdyb = 1'b1;
        repeat (3) @(posedge clk);
        chk_on = 1'b1;

        @(negedge clk);
        chk("rst_a_tdata", 32'(a_tdata), 32'h0);
        chk("rst_a_tlast", 32'(a_tlast), 32'h0);
        chk("rst_a_tdest", 32'(a_tdest), 32'h0);
        chk("rst_b_tdata", 32'(b_tdata), 32'h0);
        chk("rst_b_tdest", 32'(b_tdest), 32'h8);
        chk("rst_b_busy",  32'(b_busy),  32'h0);

        @(posedge clk); #2 sresetn = 1'b1;
        repeat (10) @(posedge clk);
        chk("lit_a_count", 32'(capa.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < capa.size(); i++)
            chk($sformatf("lit_a_beat%0d", i), 32'(capa[i]), 32'(exp_a[i % 4]));

        capb.delete();
        pulse_trigb();
        wait_b_idle("lit_b_idle");
        chk("lit_b_count", 32'(capb.size()), 32'd4);
        for (int i = 0; i < 4 && i < capb.size(); i++)
            chk($sformatf("lit_b_beat%0d", i), 32'(capb[i]), 32'(exp_b[i]));

        // Two extra triggers mid-frame collapse into exactly one extra frame.
        capb.delete();
        @(posedge clk); #2 trigb = 1'b1;
        @(posedge clk); #2 trigb = 1'b0;
        @(posedge clk); #2 trigb = 1'b1;
        @(posedge clk); #2 trigb = 1'b1;
        @(posedge clk); #2 trigb = 1'b0;
        wait_b_idle("dbl_b_idle");
        chk("dbl_b_count", 32'(capb.size()), 32'd8);

        capb.delete();
        enb = 4'b0000;
        pulse_trigb();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("zero_en_count", 32'(capb.size()), 32'd0);
        chk("zero_en_busy",  32'(b_busy),      32'd0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            veca  = $urandom;
            vecb  = {$urandom, $urandom};
            ena   = 2'($urandom);
            enb   = 4'($urandom);
            triga = 1'($urandom);
            trigb = ($urandom_range(0, 15) == 0);
            trdya = ($urandom_range(0, 3) != 0);
            trdyb = ($urandom_range(0, 3) != 0);
        end

        @(posedge clk); #2;
        veca  = {16'h1234, 16'hBEEF};
        ena   = 2'b11;
        trdya = 1'b1;
        trigb = 1'b0;
        trdyb = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (a_tvalid && a_tlast && a_tdest == 4'd1) begin
                found   = 1'b1;
                sresetn = 1'b0;
            end
        end
        chk("rst_mid_found", 32'(found), 32'd1);
        @(negedge clk);
        chk("rst_mid_tvalid", 32'(a_tvalid), 32'd0);
        capa.delete();
        sresetn = 1'b1;
        repeat (6) @(posedge clk);
        chk("rst_mid_count", 32'(capa.size() >= 2), 32'd1);
        for (int i = 0; i < 2 && i < capa.size(); i++)
            chk($sformatf("rst_mid_beat%0d", i), 32'(capa[i]), 32'(exp_a[i]));

        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
